// File: rtl/ras_pkg.sv
// Core type constants for the return address stack.
// Consumed by ras via import ras_pkg::*.
package ras_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int LOG_RAS_ENTRIES  = 3;
    localparam int RAS_TARGET_WIDTH = 31;

endpackage : ras_pkg

// File: rtl/ras.sv
// Return address stack: circular stack of PC[31:1] return targets with a checkpointable pointer.
// Optional empty detection (live-entry count, no wrap on empty pop) enabled by RAS_EMPTY_DETECT_EN.
module ras
    import ras_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       link_valid,
    input  logic [31:0]                link_full_PC,
    input  logic                       ret_valid,
    output logic [31:0]                ret_full_PC,
    output logic                       ret_target_valid,
    output logic [LOG_RAS_ENTRIES-1:0] ras_index,
    input  logic                       update_valid,
    input  logic [LOG_RAS_ENTRIES-1:0] update_ras_index
);

    localparam logic [LOG_RAS_ENTRIES-1:0] PTR_ONE = LOG_RAS_ENTRIES'(1);

    logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
    logic [RAS_TARGET_WIDTH-1:0] stack_d [RAS_ENTRIES];
    logic [LOG_RAS_ENTRIES-1:0]  ptr_q;
    logic [LOG_RAS_ENTRIES-1:0]  ptr_d;
    logic [LOG_RAS_ENTRIES-1:0]  ptr_inc_s;
    logic [LOG_RAS_ENTRIES-1:0]  ptr_dec_s;
    logic [RAS_TARGET_WIDTH-1:0] push_target_s;
    logic                        unused_pc_lsb;

    assign ptr_inc_s     = ptr_q + PTR_ONE;
    assign ptr_dec_s     = ptr_q - PTR_ONE;
    assign push_target_s = link_full_PC[31:1];
    assign unused_pc_lsb = link_full_PC[0];

    assign ret_full_PC = {stack_q[ptr_q], 1'b0};
    assign ras_index   = ptr_q;

`ifdef RAS_EMPTY_DETECT_EN
    localparam logic [LOG_RAS_ENTRIES:0] COUNT_FULL = (LOG_RAS_ENTRIES + 1)'(RAS_ENTRIES);
    localparam logic [LOG_RAS_ENTRIES:0] COUNT_ONE  = (LOG_RAS_ENTRIES + 1)'(1);
    localparam logic [LOG_RAS_ENTRIES:0] COUNT_ZERO = (LOG_RAS_ENTRIES + 1)'(0);

    logic [LOG_RAS_ENTRIES:0] count_q;
    logic [LOG_RAS_ENTRIES:0] count_d;

    assign ret_target_valid = (count_q != COUNT_ZERO);

    // Next-state: restore beats push/pop; a restore assumes every slot is live since count is not checkpointed.
    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (update_valid) begin
            ptr_d   = update_ras_index;
            count_d = COUNT_FULL;
        end else if (link_valid && ret_valid) begin
            stack_d[ptr_q] = push_target_s;
            if (count_q == COUNT_ZERO) begin
                count_d = COUNT_ONE;
            end else begin
                count_d = count_q;
            end
        end else if (link_valid) begin
            ptr_d              = ptr_inc_s;
            stack_d[ptr_inc_s] = push_target_s;
            if (count_q == COUNT_FULL) begin
                count_d = count_q;
            end else begin
                count_d = count_q + COUNT_ONE;
            end
        end else if (ret_valid) begin
            if (count_q != COUNT_ZERO) begin
                ptr_d   = ptr_dec_s;
                count_d = count_q - COUNT_ONE;
            end else begin
                ptr_d   = ptr_q;
                count_d = count_q;
            end
        end else begin
            ptr_d   = ptr_q;
            count_d = count_q;
        end
    end

    // State registers: stack, pointer and live-entry count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            stack_q <= stack_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end
`else
    assign ret_target_valid = 1'b1;

    // Next-state: pure circular buffer, pops always move the pointer.
    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        if (update_valid) begin
            ptr_d = update_ras_index;
        end else if (link_valid && ret_valid) begin
            stack_d[ptr_q] = push_target_s;
        end else if (link_valid) begin
            ptr_d              = ptr_inc_s;
            stack_d[ptr_inc_s] = push_target_s;
        end else if (ret_valid) begin
            ptr_d = ptr_dec_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers: stack and pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= '0;
            end
            ptr_q <= '0;
        end else begin
            stack_q <= stack_d;
            ptr_q   <= ptr_d;
        end
    end
`endif

endmodule : ras

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus randomized traffic against a behavioural stack model.
// Expectations follow RAS_EMPTY_DETECT_EN when it is defined for the build.
module tb_ras;

`ifdef RAS_EMPTY_DETECT_EN
    localparam bit EMPTY_DET = 1'b1;
`else
    localparam bit EMPTY_DET = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        link_valid = 1'b0;
    logic [31:0] link_full_PC = 32'h0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_full_PC;
    logic        ret_target_valid;
    logic [2:0]  ras_index;
    logic        update_valid = 1'b0;
    logic [2:0]  update_ras_index = 3'd0;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model: 8 slots of full PCs (bit 0 cleared), integer top pointer and live count
    logic [31:0] m_stack [8];
    int          m_ptr;
    int          m_cnt;

    ras dut (
        .CLK              (CLK),
        .RST              (RST),
        .link_valid       (link_valid),
        .link_full_PC     (link_full_PC),
        .ret_valid        (ret_valid),
        .ret_full_PC      (ret_full_PC),
        .ret_target_valid (ret_target_valid),
        .ras_index        (ras_index),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_stack[i] = 32'h0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    function automatic logic exp_valid();
        return EMPTY_DET ? (m_cnt != 0) : 1'b1;
    endfunction

    // one clock of stimulus; model advances with the rules applied to the pre-edge state
    task automatic step(input logic lk, input logic [31:0] pc, input logic rt,
                        input logic up, input logic [2:0] idx);
        link_valid = lk; link_full_PC = pc; ret_valid = rt;
        update_valid = up; update_ras_index = idx;
        @(posedge CLK);
        #1;
        link_valid = 1'b0; ret_valid = 1'b0; update_valid = 1'b0;
        if (up) begin
            m_ptr = idx;
            m_cnt = 8;
        end else if (lk && rt) begin
            m_stack[m_ptr] = pc & 32'hFFFF_FFFE;
            if (m_cnt == 0) m_cnt = 1;
        end else if (lk) begin
            m_ptr = (m_ptr + 1) % 8;
            m_stack[m_ptr] = pc & 32'hFFFF_FFFE;
            if (m_cnt < 8) m_cnt = m_cnt + 1;
        end else if (rt) begin
            if (!EMPTY_DET || m_cnt > 0) begin
                m_ptr = (m_ptr + 7) % 8;
                if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic apply_reset();
        #2 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (ras_index !== 3'd0 || ret_full_PC !== 32'h0 || ret_target_valid !== exp_valid()) begin
            n_errors++;
            $display("FAIL reset: idx=%0d pc=%h v=%b, required idx=0 pc=0 v=%b",
                     ras_index, ret_full_PC, ret_target_valid, exp_valid());
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] exp_pc;
        apply_reset();
        step(1'b1, 32'h1000, 1'b0, 1'b0, 3'd0);
        step(1'b1, 32'h2000, 1'b0, 1'b0, 3'd0);
        step(1'b1, 32'h3001, 1'b0, 1'b0, 3'd0);
        n_checks++;
        if (ras_index !== 3'd3 || ret_full_PC !== 32'h3000) begin
            n_errors++;
            $display("FAIL push3: idx=%0d pc=%h, required idx=3 pc=00003000", ras_index, ret_full_PC);
        end
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h3000 - 32'h1000 * i;
            n_checks++;
            if (ret_full_PC !== exp_pc) begin
                n_errors++;
                $display("FAIL pop_target[%0d]: got %h, required %h", i, ret_full_PC, exp_pc);
            end
            step(1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        end
        n_checks++;
        if (ras_index !== 3'd0) begin
            n_errors++;
            $display("FAIL pop3_index: got %0d, required 0", ras_index);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        apply_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, 32'h100 * i, 1'b0, 1'b0, 3'd0);
        n_checks++;
        if (ras_index !== 3'd1 || ret_full_PC !== 32'h900) begin
            n_errors++;
            $display("FAIL overflow_top: idx=%0d pc=%h, required idx=1 pc=00000900", ras_index, ret_full_PC);
        end
        for (int i = 0; i < 8; i++) begin
            exp_pc = 32'h900 - 32'h100 * i;
            n_checks++;
            if (ret_full_PC !== exp_pc || ret_target_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL overflow_pop[%0d]: pc=%h v=%b, required pc=%h v=1",
                         i, ret_full_PC, ret_target_valid, exp_pc);
            end
            step(1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        end
        n_checks++;
        if (ret_target_valid !== exp_valid() || ras_index !== 3'd1) begin
            n_errors++;
            $display("FAIL drained: idx=%0d v=%b, required idx=1 v=%b", ras_index, ret_target_valid, exp_valid());
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        n_checks++;
        if (ras_index !== (EMPTY_DET ? 3'd1 : 3'd0) || ret_target_valid !== exp_valid()) begin
            n_errors++;
            $display("FAIL ninth_pop: idx=%0d v=%b, required idx=%0d v=%b",
                     ras_index, ret_target_valid, EMPTY_DET ? 1 : 0, exp_valid());
        end
    endtask

    task automatic test_coroutine();
        apply_reset();
        step(1'b1, 32'hA0, 1'b0, 1'b0, 3'd0);
        link_valid = 1'b1; link_full_PC = 32'hB0; ret_valid = 1'b1;
        #1;
        n_checks++;
        if (ret_full_PC !== 32'hA0) begin
            n_errors++;
            $display("FAIL coroutine_pre: got %h, required 000000a0", ret_full_PC);
        end
        step(1'b1, 32'hB0, 1'b1, 1'b0, 3'd0);
        n_checks++;
        if (ras_index !== 3'd1 || ret_full_PC !== 32'hB0 || ret_target_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL coroutine: idx=%0d pc=%h v=%b, required idx=1 pc=000000b0 v=1",
                     ras_index, ret_full_PC, ret_target_valid);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        n_checks++;
        if (ras_index !== 3'd0 || ret_full_PC !== 32'h0) begin
            n_errors++;
            $display("FAIL coroutine_pop: idx=%0d pc=%h, required idx=0 pc=0", ras_index, ret_full_PC);
        end
    endtask

    task automatic test_update();
        apply_reset();
        step(1'b1, 32'h40, 1'b0, 1'b0, 3'd0);
        step(1'b1, 32'h80, 1'b0, 1'b0, 3'd0);
        step(1'b1, 32'hC0, 1'b0, 1'b1, 3'd1);
        n_checks++;
        if (ras_index !== 3'd1 || ret_full_PC !== 32'h40 || ret_target_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL update: idx=%0d pc=%h v=%b, required idx=1 pc=00000040 v=1",
                     ras_index, ret_full_PC, ret_target_valid);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 3'd2);
        n_checks++;
        if (ret_full_PC !== 32'h80) begin
            n_errors++;
            $display("FAIL update_dropped_push: slot2=%h, required 00000080", ret_full_PC);
        end
    endtask

    task automatic test_empty_pop();
        apply_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        n_checks++;
        if (ras_index !== (EMPTY_DET ? 3'd0 : 3'd7) || ret_full_PC !== 32'h0 ||
            ret_target_valid !== !EMPTY_DET) begin
            n_errors++;
            $display("FAIL empty_pop: idx=%0d pc=%h v=%b, required idx=%0d pc=0 v=%b",
                     ras_index, ret_full_PC, ret_target_valid, EMPTY_DET ? 0 : 7, !EMPTY_DET);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1'b1, 32'h1234, 1'b0, 1'b0, 3'd0);
        step(1'b1, 32'h5678, 1'b0, 1'b0, 3'd0);
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if (ras_index !== 3'd0 || ret_full_PC !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: idx=%0d pc=%h, required idx=0 pc=0", ras_index, ret_full_PC);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic        lk, rt, up;
        logic [31:0] pc;
        logic [2:0]  idx;
        int          r;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            r   = int'($urandom_range(0, 99));
            up  = (r < 5);
            lk  = ($urandom_range(0, 99) < 50);
            rt  = ($urandom_range(0, 99) < 45);
            pc  = $urandom;
            idx = 3'($urandom_range(0, 7));
            step(lk, pc, rt, up, idx);
            n_checks++;
            if (ras_index !== 3'(m_ptr) || ret_full_PC !== m_stack[m_ptr] ||
                ret_target_valid !== exp_valid()) begin
                n_errors++;
                $display("FAIL random[%0d]: idx=%0d pc=%h v=%b, required idx=%0d pc=%h v=%b",
                         c, ras_index, ret_full_PC, ret_target_valid, m_ptr, m_stack[m_ptr], exp_valid());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_push_pop();
        test_overflow();
        test_coroutine();
        test_update();
        test_empty_pop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ras
